seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner: IDLE / SHOW / BLANK sequencing with registered outputs.
// Optional build macro SEG_SCAN_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg_scan_ctrl #(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [1:0]  digit_idx
);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  localparam logic [16:0] TICK_LAST  = 17'(TICK_DIV - 1);
  localparam logic [7:0]  BLANK_LAST = 8'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit          HAS_BLANK  = (BLANK_CYCLES > 0);

  state_t      state_q, state_d;
  logic [16:0] presc_q, presc_d;
  logic [7:0]  blank_q, blank_d;
  logic [1:0]  idx_d;
  logic [3:0]  nib_q, nib_d;
  logic        dpb_q, dpb_d;
  logic [3:0]  an_d;
  logic [6:0]  seg_d;
  logic        dpn_d;
  logic        load;
  logic        lz;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    blank_d = blank_q;
    idx_d   = digit_idx;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SHOW;
          presc_d = '0;
          load    = 1'b1;
        end
      end
      SHOW: begin
        if (!en) begin
          state_d = IDLE;
          presc_d = '0;
          blank_d = '0;
        end else if (presc_q == TICK_LAST) begin
          presc_d = '0;
          if (HAS_BLANK) begin
            state_d = BLANK;
            blank_d = '0;
          end else begin
            // Back-to-back slots: re-enter SHOW directly on the next digit.
            idx_d = digit_idx + 2'd1;
            load  = 1'b1;
          end
        end else begin
          presc_d = presc_q + 17'd1;
        end
      end
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
          presc_d = '0;
          blank_d = '0;
        end else if (blank_q == BLANK_LAST) begin
          blank_d = '0;
          idx_d   = digit_idx + 2'd1;
          state_d = SHOW;
          load    = 1'b1;
        end else begin
          blank_d = blank_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    nib_d = load ? value[{idx_d, 2'b00} +: 4] : nib_q;
    dpb_d = load ? dp[idx_d] : dpb_q;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    lz = (idx_d != 2'd0) && ((value >> {idx_d, 2'b00}) == 16'h0000);
`else
    lz = 1'b0;
`endif

    // Outputs are computed for the next state so they change on the same edge as the state.
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dpn_d = 1'b1;
    if (state_d == SHOW) begin
      if (load) begin
        an_d  = ~(4'b0001 << idx_d);
        seg_d = lz ? 7'b1111111 : hex_to_seg(nib_d);
        dpn_d = ~dpb_d;
      end else begin
        an_d  = an;
        seg_d = seg;
        dpn_d = dp_n;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      blank_q   <= '0;
      digit_idx <= '0;
      nib_q     <= '0;
      dpb_q     <= 1'b0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp_n      <= 1'b1;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      blank_q   <= blank_d;
      digit_idx <= idx_d;
      nib_q     <= nib_d;
      dpb_q     <= dpb_d;
      an        <= an_d;
      seg       <= seg_d;
      dp_n      <= dpn_d;
    end
  end

endmodule
